ram_burst_ctrl: RTL

- Request sequencer that sits directly upstream of ram_block and is the only driver of its address, data_in and we pins.
- Accepts burst read/write commands over a valid/ready handshake. Streams write beats into the RAM and returns read beats with backpressure.
- Auto-increments the RAM address on each beat.

---
 rtl/ram_ctrl_pkg.sv | 18 +
 rtl/burst_addr_cnt.sv | 46 ++++
 rtl/ram_burst_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM burst controller and ram_block: state
// encoding and default bus widths.
package ram_ctrl_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/burst_addr_cnt.sv
// Loadable wrapping address counter paired with a beat down-counter; last_o
// flags the final beat of the burst.
module burst_addr_cnt #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  left_q, left_d;

    // The address wraps naturally at 2^ADDR_W; stepping on the last beat is ignored.
    always_comb begin
        addr_d = addr_q;
        left_d = left_q;
        if (load_i) begin
            addr_d = addr_i;
            left_d = len_i;
        end else if (step_i && (left_q != '0)) begin
            addr_d = addr_q + ADDR_W'(1);
            left_d = left_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            left_q <= '0;
        end else begin
            addr_q <= addr_d;
            left_q <= left_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (left_q == '0);

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of ram_block: accepts read/write burst commands,
// streams write beats into the RAM and returns read beats with backpressure.
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              cnt_load, cnt_step, cnt_last;
    logic [ADDR_W-1:0] cur_addr;

    burst_addr_cnt #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (cnt_load),
        .step_i (cnt_step),
        .addr_i (req_addr),
        .len_i  (req_len),
        .addr_o (cur_addr),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        rd_data_d = rd_data_q;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_load = 1'b1;
                    state_d  = req_we ? WRITE : RD_ISSUE;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    if (cnt_last) state_d  = DONE;
                    else          cnt_step = 1'b1;
                end
            end
            RD_ISSUE: begin
                lat_d   = LAT_W'(RD_LATENCY - 1);
                state_d = RD_WAIT;
            end
            // ram_addr has been stable since RD_ISSUE, so data is valid once lat_q hits 0.
            RD_WAIT: begin
                if (lat_q == '0) begin
                    rd_data_d = ram_data_out;
                    state_d   = RD_HOLD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    if (cnt_last) begin
                        state_d = DONE;
                    end else begin
                        cnt_step = 1'b1;
                        state_d  = RD_ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write strobe is combinational so the RAM captures on the handshake edge.
    always_comb begin
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        rd_valid    = 1'b0;
        done        = 1'b0;
        ram_we      = 1'b0;
        ram_data_in = '0;
        ram_addr    = cur_addr;
        rd_data     = rd_data_q;
        case (state_q)
            IDLE:  req_ready = 1'b1;
            WRITE: begin
                wr_ready    = 1'b1;
                ram_we      = wr_valid;
                ram_data_in = wr_data;
            end
            RD_HOLD: rd_valid = 1'b1;
            DONE:    done     = 1'b1;
            default: ;
        endcase
    end

endmodule
